id_ex_issue: RTL and testbench

ID/EX pipeline register and operand-issue stage sitting directly upstream of the ALU. It captures decoded fields from ID, decodes opcode/funct into the 3-bit ALU control code, and selects immediate vs register operands. It resolves EX/MEM and MEM/WB forwarding, then presents `data1_o`, `data2_o` and `ALUCtrl_o` to the ALU. It supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/alu_ctrl_decode.sv | 53 +++++
 rtl/id_ex_issue.sv | 110 +++++++++++
 tb/tb_id_ex_issue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ID/EX issue stage: ALU control codes, opcode and
// funct7 encodings, the registered issue-slot layout and the forwarding mux.
package cpu_pkg;

    localparam int XLEN = 32;

    // ALU control codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SRAI = 3'b110;

    // Major opcodes
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // funct7 encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // Everything captured at the ID/EX boundary for one instruction slot.
    // An all-zero slot is a bubble.
    typedef struct packed {
        logic            valid;
        logic [2:0]      alu_ctrl;
        logic            alu_src;
        logic            regwrite;
        logic            illegal;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } issue_slot_t;

    // Operand bypass: EX/MEM beats MEM/WB, and x0 never forwards.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [4:0]      src,
        input logic [XLEN-1:0] reg_data,
        input logic            ex_we,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] result;
        result = reg_data;
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == src)) begin
            result = ex_data;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            result = wb_data;
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: opcode/funct3/funct7 -> ALU code,
// immediate-select and legality. Unsupported encodings decode to ADD, reg operand.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [2:0] alu_ctrl_o,
    output logic       alu_src_o,
    output logic       legal_o
);

    // Table lookup of the supported R-type and I-type operations
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        alu_src_o  = 1'b0;
        legal_o    = 1'b0;
        if (opcode_i == OP_R) begin
            if (funct7_i == F7_BASE && funct3_i == 3'b000) begin
                alu_ctrl_o = ALU_ADD;
                legal_o    = 1'b1;
            end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                alu_ctrl_o = ALU_SUB;
                legal_o    = 1'b1;
            end else if (funct7_i == F7_MUL && funct3_i == 3'b000) begin
                alu_ctrl_o = ALU_MUL;
                legal_o    = 1'b1;
            end else if (funct7_i == F7_BASE && funct3_i == 3'b111) begin
                alu_ctrl_o = ALU_AND;
                legal_o    = 1'b1;
            end else if (funct7_i == F7_BASE && funct3_i == 3'b100) begin
                alu_ctrl_o = ALU_XOR;
                legal_o    = 1'b1;
            end else if (funct7_i == F7_BASE && funct3_i == 3'b001) begin
                alu_ctrl_o = ALU_SLL;
                legal_o    = 1'b1;
            end
        end else if (opcode_i == OP_I) begin
            // funct7 overlaps imm[11:5]; it only matters for the shift
            if (funct3_i == 3'b000) begin
                alu_ctrl_o = ALU_ADD;
                alu_src_o  = 1'b1;
                legal_o    = 1'b1;
            end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
                alu_ctrl_o = ALU_SRAI;
                alu_src_o  = 1'b1;
                legal_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with operand issue: decodes in ID, registers the
// slot, then forwards EX/MEM and MEM/WB results into the ALU operands.
module id_ex_issue
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [11:0]     imm_i,
    input  logic            exmem_regwrite_i,
    input  logic [4:0]      exmem_rd_i,
    input  logic [XLEN-1:0] exmem_data_i,
    input  logic            memwb_regwrite_i,
    input  logic [4:0]      memwb_rd_i,
    input  logic [XLEN-1:0] memwb_data_i,
    output logic            valid_o,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [2:0]      ALUCtrl_o,
    output logic [4:0]      rd_addr_o,
    output logic            regwrite_o,
    output logic            illegal_o
);

    logic [2:0]      dec_ctrl;
    logic            dec_src;
    logic            dec_legal;
    logic [XLEN-1:0] imm_ext;
    issue_slot_t     slot_d;
    issue_slot_t     slot_q;

    alu_ctrl_decode u_decode (
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7_i   (funct7_i),
        .alu_ctrl_o (dec_ctrl),
        .alu_src_o  (dec_src),
        .legal_o    (dec_legal)
    );

    // Shifts take only the 5-bit shamt; everything else sign-extends
    always_comb begin
        imm_ext = {{(XLEN-12){imm_i[11]}}, imm_i};
        if (dec_ctrl == ALU_SRAI && dec_src) begin
            imm_ext = {{(XLEN-5){1'b0}}, imm_i[4:0]};
        end
    end

    // Next slot: flush beats stall, stall beats load; valid_i=0 loads a bubble
    always_comb begin
        slot_d = slot_q;
        if (flush_i) begin
            slot_d = '0;
        end else if (stall_i) begin
            slot_d = slot_q;
        end else if (!valid_i) begin
            slot_d = '0;
        end else begin
            slot_d.valid    = 1'b1;
            slot_d.alu_ctrl = dec_ctrl;
            slot_d.alu_src  = dec_src;
            slot_d.regwrite = dec_legal && (rd_addr_i != 5'd0);
            slot_d.illegal  = !dec_legal;
            slot_d.rs1_addr = rs1_addr_i;
            slot_d.rs2_addr = rs2_addr_i;
            slot_d.rd_addr  = rd_addr_i;
            slot_d.rs1_data = rs1_data_i;
            slot_d.rs2_data = rs2_data_i;
            slot_d.imm      = imm_ext;
        end
    end

    // Stage register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Operand issue and status outputs from the registered slot
    always_comb begin
        data1_o = fwd_operand(slot_q.rs1_addr, slot_q.rs1_data,
                              exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                              memwb_regwrite_i, memwb_rd_i, memwb_data_i);
        data2_o = fwd_operand(slot_q.rs2_addr, slot_q.rs2_data,
                              exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                              memwb_regwrite_i, memwb_rd_i, memwb_data_i);
        if (slot_q.alu_src) begin
            data2_o = slot_q.imm;
        end
        valid_o    = slot_q.valid;
        ALUCtrl_o  = slot_q.alu_ctrl;
        rd_addr_o  = slot_q.rd_addr;
        regwrite_o = slot_q.valid && slot_q.regwrite;
        illegal_o  = slot_q.valid && slot_q.illegal;
    end

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_id_ex_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic [11:0] imm_i;
    logic        exmem_regwrite_i, memwb_regwrite_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_data_i, memwb_data_i;
    logic        valid_o, regwrite_o, illegal_o;
    logic [31:0] data1_o, data2_o;
    logic [2:0]  ALUCtrl_o;
    logic [4:0]  rd_addr_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    id_ex_issue dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
        .exmem_data_i(exmem_data_i), .memwb_regwrite_i(memwb_regwrite_i),
        .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .valid_o(valid_o), .data1_o(data1_o), .data2_o(data2_o),
        .ALUCtrl_o(ALUCtrl_o), .rd_addr_o(rd_addr_o), .regwrite_o(regwrite_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model stores the raw instruction as captured and interprets it on demand.
    logic        m_valid;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2;
    logic [11:0] m_imm;

    // Returns {legal, uses_immediate, alu_code} straight from the operation table
    function automatic logic [4:0] spec_decode(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7);
        if (op == 7'b0110011) begin
            case ({f7, f3})
                {7'b0000000, 3'b000}: return 5'b10_000;
                {7'b0100000, 3'b000}: return 5'b10_100;
                {7'b0000001, 3'b000}: return 5'b10_101;
                {7'b0000000, 3'b111}: return 5'b10_001;
                {7'b0000000, 3'b100}: return 5'b10_011;
                {7'b0000000, 3'b001}: return 5'b10_010;
                default:              return 5'b00_000;
            endcase
        end
        if (op == 7'b0010011) begin
            if (f3 == 3'b000) return 5'b11_000;
            if (f3 == 3'b101 && f7 == 7'b0100000) return 5'b11_110;
        end
        return 5'b00_000;
    endfunction

    function automatic logic [31:0] bypass(input logic [4:0] src, input logic [31:0] rf);
        if (src == 0) return rf;
        if (exmem_regwrite_i && exmem_rd_i == src) return exmem_data_i;
        if (memwb_regwrite_i && memwb_rd_i == src) return memwb_data_i;
        return rf;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_op = 0; m_f3 = 0; m_f7 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0;
    endtask

    always @(posedge clk_i) begin
        if (!rst_i || flush_i) model_clear();
        else if (stall_i) ;
        else if (!valid_i) model_clear();
        else begin
            m_valid = 1; m_op = opcode_i; m_f3 = funct3_i; m_f7 = funct7_i;
            m_rs1 = rs1_addr_i; m_rs2 = rs2_addr_i; m_rd = rd_addr_i;
            m_d1 = rs1_data_i; m_d2 = rs2_data_i; m_imm = imm_i;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk_i) begin
        if (cmp_en) begin
            logic [4:0]  dec;
            logic        legal;
            logic [31:0] e_imm, e_d2;
            dec   = spec_decode(m_op, m_f3, m_f7);
            legal = dec[4] && m_valid;
            if (dec[2:0] == 3'b110) e_imm = {27'd0, m_imm[4:0]};
            else                    e_imm = {{20{m_imm[11]}}, m_imm};
            e_d2 = (legal && dec[3]) ? e_imm : bypass(m_rs2, m_d2);
            check("m_valid",    {31'd0, valid_o},    {31'd0, m_valid});
            check("m_aluctrl",  {29'd0, ALUCtrl_o},  {29'd0, legal ? dec[2:0] : 3'b000});
            check("m_rd",       {27'd0, rd_addr_o},  {27'd0, m_rd});
            check("m_regwrite", {31'd0, regwrite_o}, {31'd0, legal && m_rd != 0});
            check("m_illegal",  {31'd0, illegal_o},  {31'd0, m_valid && !dec[4]});
            check("m_data1",    data1_o,             bypass(m_rs1, m_d1));
            check("m_data2",    data2_o,             e_d2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [11:0] imm);
        valid_i = v; opcode_i = op; funct3_i = f3; funct7_i = f7;
        rs1_addr_i = r1; rs2_addr_i = r2; rd_addr_i = rd;
        rs1_data_i = d1; rs2_data_i = d2; imm_i = imm;
    endtask

    task automatic fwd_off();
        exmem_regwrite_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
        memwb_regwrite_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
    endtask

    // Random instruction drawn from legal operations plus illegal and junk encodings
    task automatic random_id();
        logic [11:0] imm;
        int sel;
        imm = 12'($urandom);
        sel = $urandom_range(0, 10);
        case (sel)
            0: drive_id(1, 7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 0, 0, imm);
            1: drive_id(1, 7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0, 0, imm);
            2: drive_id(1, 7'b0110011, 3'b000, 7'b0000001, 0, 0, 0, 0, 0, imm);
            3: drive_id(1, 7'b0110011, 3'b111, 7'b0000000, 0, 0, 0, 0, 0, imm);
            4: drive_id(1, 7'b0110011, 3'b100, 7'b0000000, 0, 0, 0, 0, 0, imm);
            5: drive_id(1, 7'b0110011, 3'b001, 7'b0000000, 0, 0, 0, 0, 0, imm);
            6: drive_id(1, 7'b0010011, 3'b000, imm[11:5], 0, 0, 0, 0, 0, imm);
            7: begin
                imm[11:5] = 7'b0100000;
                drive_id(1, 7'b0010011, 3'b101, imm[11:5], 0, 0, 0, 0, 0, imm);
            end
            8: drive_id(1, 7'b0110011, 3'b010, 7'b0000000, 0, 0, 0, 0, 0, imm);
            9: drive_id(1, 7'b0010011, 3'b101, imm[11:5], 0, 0, 0, 0, 0, imm);
            default: drive_id(1, 7'($urandom), 3'($urandom), 7'($urandom), 0, 0, 0, 0, 0, imm);
        endcase
        valid_i    = ($urandom_range(0, 7) != 0);
        rs1_addr_i = 5'($urandom_range(0, 7));
        rs2_addr_i = 5'($urandom_range(0, 7));
        rd_addr_i  = 5'($urandom_range(0, 7));
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_i = 0; stall_i = 0; flush_i = 0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwd_off();
        tick();
        tick();
        cmp_en = 1;
        check("rst_valid",    {31'd0, valid_o},    0);
        check("rst_regwrite", {31'd0, regwrite_o}, 0);
        check("rst_aluctrl",  {29'd0, ALUCtrl_o},  0);
        check("rst_data1",    data1_o,             0);
        check("rst_data2",    data2_o,             0);
        rst_i = 1;

        // add x3,x1,x2
        drive_id(1, 7'b0110011, 3'b000, 7'b0000000, 1, 2, 3, 5, 7, 12'h000);
        tick();
        check("add_valid",    {31'd0, valid_o},    1);
        check("add_aluctrl",  {29'd0, ALUCtrl_o},  0);
        check("add_data1",    data1_o,             5);
        check("add_data2",    data2_o,             7);
        check("add_regwrite", {31'd0, regwrite_o}, 1);
        check("add_rd",       {27'd0, rd_addr_o},  3);

        // addi sign extension, then srai shamt
        drive_id(1, 7'b0010011, 3'b000, 7'h7F, 1, 2, 5, 1, 2, 12'hFFF);
        tick();
        check("addi_data2",   data2_o,            32'hFFFF_FFFF);
        check("addi_aluctrl", {29'd0, ALUCtrl_o}, 0);
        drive_id(1, 7'b0010011, 3'b101, 7'b0100000, 1, 3, 5, 1, 2, 12'h403);
        tick();
        check("srai_data2",   data2_o,            3);
        check("srai_aluctrl", {29'd0, ALUCtrl_o}, 3'b110);

        // forwarding priority on rs1=x4
        drive_id(1, 7'b0110011, 3'b000, 7'b0000000, 4, 6, 7, 32'h11, 32'h22, 0);
        tick();
        exmem_regwrite_i = 1; exmem_rd_i = 4; exmem_data_i = 32'hAA;
        memwb_regwrite_i = 1; memwb_rd_i = 4; memwb_data_i = 32'hBB;
        #1 check("fwd_exmem", data1_o, 32'hAA);
        exmem_regwrite_i = 0;
        #1 check("fwd_memwb", data1_o, 32'hBB);
        exmem_regwrite_i = 1; exmem_rd_i = 0; memwb_rd_i = 0;
        #1 check("fwd_x0", data1_o, 32'h11);
        fwd_off();

        // mul held through a 3-cycle stall, then flush wins over stall
        drive_id(1, 7'b0110011, 3'b000, 7'b0000001, 1, 2, 9, 3, 4, 0);
        tick();
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            random_id();
            tick();
            check("stall_aluctrl", {29'd0, ALUCtrl_o}, 3'b101);
            check("stall_rd",      {27'd0, rd_addr_o}, 9);
        end
        flush_i = 1;
        tick();
        check("flush_valid", {31'd0, valid_o}, 0);
        flush_i = 0; stall_i = 0;

        // slt is unsupported
        drive_id(1, 7'b0110011, 3'b010, 7'b0000000, 1, 2, 3, 5, 7, 0);
        tick();
        check("slt_illegal",  {31'd0, illegal_o},  1);
        check("slt_regwrite", {31'd0, regwrite_o}, 0);
        check("slt_aluctrl",  {29'd0, ALUCtrl_o},  0);
        valid_i = 0;
        tick();
        check("slt_bubble_illegal", {31'd0, illegal_o}, 0);

        // reset during a stall clears everything
        drive_id(1, 7'b0110011, 3'b000, 7'b0100000, 1, 2, 3, 5, 7, 0);
        tick();
        stall_i = 1; rst_i = 0;
        tick();
        check("rst2_valid",   {31'd0, valid_o},   0);
        check("rst2_rd",      {27'd0, rd_addr_o}, 0);
        check("rst2_data1",   data1_o,            0);
        check("rst2_data2",   data2_o,            0);
        stall_i = 0; rst_i = 1;

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 600; i++) begin
            random_id();
            stall_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            rst_i   = ($urandom_range(0, 49) != 0);
            exmem_regwrite_i = $urandom_range(0, 1);
            exmem_rd_i       = 5'($urandom_range(0, 7));
            exmem_data_i     = $urandom;
            memwb_regwrite_i = $urandom_range(0, 1);
            memwb_rd_i       = 5'($urandom_range(0, 7));
            memwb_data_i     = $urandom;
            tick();
        end
        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
